front_panel_ctrl: RTL
=====================

// Module: front_panel_ctrl
// PURPOSE
//  Console sequencer behind the Altair front panel: consumes the 25 switch states produced by the
//  panel renderer and drives its 36-bit LED word. Decodes switch transitions into
//  examine/deposit/step/reset actions, runs a memory-bus handshake while the CPU is stopped, and
//  passes live CPU bus state to the LEDs while running.
// PARAMETERS
//  SETTLE_CYCLES  16   cycles a new switch value must hold before it is acted on
//  ACK_TIMEOUT    255  max cycles waiting for mem_ack before a transaction aborts
// PORTS
//  clk              in   1      system clock (same clock as the panel renderer)
//  reset            in   1      asynchronous, active-high
//  switches_status  in   [1:0] x [0:24]  panel switches (see BEHAVIOUR for index map)
//  leds_status      out  [0:35] LED word to the panel renderer
//  cpu_addr_in      in   16     live CPU address bus
//  cpu_data_in      in   8      live CPU data bus
//  cpu_status_in    in   10     INTE,PROT,MEMR,INP,M1,OUT,HLTA,STACK,WO,INT
//  cpu_run          out  1      1 = CPU may execute
//  cpu_reset        out  1      CPU reset, 1-cycle pulse
//  cpu_step         out  1      single-instruction step, 1-cycle pulse
//  mem_addr         out  16     console memory address
//  mem_wdata        out  8      console write data
//  mem_we           out  1      1 = write, 0 = read
//  mem_req          out  1      request, held until ack
//  mem_ack          in   1      1-cycle acknowledge; mem_rdata valid the same cycle
//  mem_rdata        in   8      read data
// BEHAVIOUR
//  Switch map: 0-15 address/data (1=up); 16 ON/OFF (1=ON); 17 STOP/RUN (1=STOP); double throw
//   (2=up,1=down,0=centre): 18 EXAMINE/EXAMINE NEXT, 19 DEPOSIT/DEPOSIT NEXT, 20 RESET/CLR,
//   21 PROTECT/UNPROTECT, 22 SINGLE STEP (either side); 23-24 AUX (ignored).
//  LED map: [0:9]=cpu_status order above, 10=WAIT, 11=HLDA(0), [12:19]=D7..D0, [20:35]=A15..A0.
//  Settling: per-switch counter; a value is committed after SETTLE_CYCLES identical samples.
//   An action fires once, on a committed transition centre(0) -> up/down. Returning to centre
//   re-arms the switch. No auto-repeat.
//  FSM: OFF, RUN, IDLE, RD_REQ, WR_REQ, STEP. Reset -> OFF, all outputs 0, addr_reg=0, data_reg=0.
//   OFF: sw16=0; cpu_run=0, leds all 0, actions dropped. sw16 -> 1: cpu_reset pulse, -> IDLE/RUN per sw17.
//   RUN: cpu_run=1; leds = {cpu_status_in, 0, 0, cpu_data_in, cpu_addr_in}, registered (1-cycle lag).
//    sw17 -> 1 enters IDLE; addr_reg <= cpu_addr_in, data_reg <= cpu_data_in.
//   IDLE: cpu_run=0, WAIT LED=1; leds show data_reg, addr_reg. sw17 -> 0 returns to RUN.
//   Priority for same-cycle committed actions: RESET > EXAMINE > DEPOSIT > STEP > PROTECT; losers dropped.
//   EXAMINE up: addr_reg<=sw[15:0]; down: addr_reg<=addr_reg+1 (0xFFFF wraps to 0x0000); -> RD_REQ.
//   DEPOSIT up: write sw[7:0] at addr_reg; down: addr_reg+1 first, then write; WR_REQ then RD_REQ readback.
//   RESET up: cpu_reset pulse, addr_reg<=0; CLR (down): no operation.
//   STEP: cpu_step pulse 1 cycle, next cycle capture cpu_addr_in/cpu_data_in into addr/data_reg.
//  Handshake: mem_req rises the cycle after state entry; addr/we/wdata stable while mem_req=1;
//   mem_req drops the cycle after mem_ack=1 (read: data_reg<=mem_rdata). No ack within
//   ACK_TIMEOUT cycles -> mem_req drops, data_reg<=0xFF, -> IDLE. Write is one transaction.
//  Actions committed while in RD_REQ/WR_REQ/STEP are dropped. sw17 -> 0 during a transaction
//   takes effect after it completes. sw16 -> 0 aborts immediately to OFF (mem_req=0 next cycle).
//  Async reset mid-transaction: mem_req/cpu_* drop immediately, FSM -> OFF.
// CONFIGURATION
//  FP_PROTECT_EN defined: 64-bit protect map, one bit per 1 KB block (addr_reg[15:10]);
//   PROTECT up sets, down clears bit of addr_reg's block; deposit to protected block skips write
//   (readback still issued); LED 1 (PROT) in IDLE = bit of addr_reg block; reset clears map.
//  Not defined: switch 21 ignored, no map, LED 1 always cpu_status_in bit in RUN, 0 in IDLE.
// TESTING
//  sw16=1,sw17=1, sw[15:0]=0x1234, sw18 0->2 -> mem_req, mem_addr=0x1234, mem_we=0; ack rdata=0x5A -> leds D=0x5A, A=0x1234.
//  then sw18 0->1 twice -> reads at 0x1235, 0x1236; at addr_reg=0xFFFF examine-next -> mem_addr=0x0000.
//  sw[7:0]=0xC3, sw19 0->2 -> write 0xC3 @addr_reg then read @addr_reg; 0xC3 shown on D LEDs.
//  no mem_ack for ACK_TIMEOUT cycles -> mem_req=0, D LEDs=0xFF, FSM accepts next examine.
//  sw18 and sw20 committed same cycle -> only cpu_reset pulse, addr_reg=0, no mem_req.
//  FP_PROTECT_EN: protect block 0x04, deposit-next at 0x1000 -> no mem_we=1 transaction, PROT LED=1.

Source files
------------

// File: rtl/front_panel_ctrl.sv
// front_panel_ctrl: Altair console sequencer; define FP_PROTECT_EN for the 1 KB-block protect map
module front_panel_ctrl #(
  parameter int SETTLE_CYCLES = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  switches_status [0:24],
  output logic [0:35] leds_status,
  input  logic [15:0] cpu_addr_in,
  input  logic [7:0]  cpu_data_in,
  input  logic [9:0]  cpu_status_in,
  output logic        cpu_run,
  output logic        cpu_reset,
  output logic        cpu_step,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata
);
  localparam logic [2:0] OFF = 3'd0, RUN = 3'd1, IDLE = 3'd2, RD_REQ = 3'd3, WR_REQ = 3'd4, STEP = 3'd5;
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  logic [2:0] state;
  logic [15:0] addr_reg, na, sw_addr, sw_hi;
  logic [7:0] data_reg;
  logic [TW-1:0] tmo;
  logic [1:0] smp [16:22];
  logic [1:0] com [16:22];
  logic [1:0] com_d [16:22];
  logic [CW-1:0] cnt [16:22];
  logic [18:22] fire;
  logic on, stop, prot_hit, prot_led, unused_ok;
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      sw_addr[i] = switches_status[i][0];
      sw_hi[i] = switches_status[i][1];
    end
    for (int i = 18; i <= 22; i++) fire[i] = com_d[i] == 2'd0 && com[i] != 2'd0;
  end
  assign on = com[16] != 2'd0;
  assign stop = com[17] != 2'd0;
  assign na = com[19][1] ? addr_reg : addr_reg + 16'd1;
`ifdef FP_PROTECT_EN
  logic [63:0] pmap;
  assign prot_hit = pmap[na[15:10]];
  assign prot_led = pmap[addr_reg[15:10]];
  assign unused_ok = ^{sw_hi, switches_status[23], switches_status[24]};
`else
  assign prot_hit = 1'b0;
  assign prot_led = 1'b0;
  assign unused_ok = ^{sw_hi, switches_status[23], switches_status[24], fire[21], com[21]};
`endif
  // A switch value commits only after it has held steady for SETTLE_CYCLES samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 16; i <= 22; i++) begin
        smp[i] <= '0;
        com[i] <= '0;
        com_d[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 16; i <= 22; i++) begin
        com_d[i] <= com[i];
        if (switches_status[i] != smp[i]) begin
          smp[i] <= switches_status[i];
          cnt[i] <= '0;
        end else if (cnt[i] != CW'(SETTLE_CYCLES - 1)) cnt[i] <= cnt[i] + 1'b1;
        else com[i] <= smp[i];
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= OFF;
      cpu_run <= 1'b0;
      cpu_reset <= 1'b0;
      cpu_step <= 1'b0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      addr_reg <= '0;
      data_reg <= '0;
      tmo <= '0;
      leds_status <= '0;
`ifdef FP_PROTECT_EN
      pmap <= '0;
`endif
    end else begin
      cpu_reset <= 1'b0;
      cpu_step <= 1'b0;
      leds_status <= state == OFF ? 36'd0 :
                     state == RUN ? {cpu_status_in, 2'b00, cpu_data_in, cpu_addr_in} :
                     {1'b0, prot_led, 8'd0, 1'b1, 1'b0, data_reg, addr_reg};
      if (!on && state != OFF) begin
        state <= OFF;
        cpu_run <= 1'b0;
        mem_req <= 1'b0;
        mem_we <= 1'b0;
      end else begin
        case (state)
          OFF: if (on) begin
            cpu_reset <= 1'b1;
            cpu_run <= !stop;
            state <= stop ? IDLE : RUN;
          end
          RUN: if (stop) begin
            cpu_run <= 1'b0;
            addr_reg <= cpu_addr_in;
            data_reg <= cpu_data_in;
            state <= IDLE;
          end else if (fire[20] && com[20][1]) begin
            cpu_reset <= 1'b1;
            addr_reg <= '0;
          end
          IDLE: if (!stop) begin
            cpu_run <= 1'b1;
            state <= RUN;
          end else if (fire[20]) begin
            cpu_reset <= com[20][1];
            if (com[20][1]) addr_reg <= '0;
          end else if (fire[18]) begin
            addr_reg <= com[18][1] ? sw_addr : addr_reg + 16'd1;
            state <= RD_REQ;
          end else if (fire[19]) begin
            addr_reg <= na;
            data_reg <= sw_addr[7:0];
            state <= prot_hit ? RD_REQ : WR_REQ;
          end else if (fire[22]) begin
            cpu_step <= 1'b1;
            state <= STEP;
          end
`ifdef FP_PROTECT_EN
          else if (fire[21]) pmap[addr_reg[15:10]] <= com[21][1];
`endif
          RD_REQ, WR_REQ: if (!mem_req) begin
            mem_req <= 1'b1;
            mem_we <= state == WR_REQ;
            mem_addr <= addr_reg;
            mem_wdata <= data_reg;
            tmo <= '0;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            if (state == RD_REQ) data_reg <= mem_rdata;
            state <= state == WR_REQ ? RD_REQ : IDLE;
          end else if (tmo == TW'(ACK_TIMEOUT - 1)) begin
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            data_reg <= 8'hFF;
            state <= IDLE;
          end else tmo <= tmo + 1'b1;
          STEP: begin
            addr_reg <= cpu_addr_in;
            data_reg <= cpu_data_in;
            state <= IDLE;
          end
          default: state <= OFF;
        endcase
      end
    end
  end
endmodule
